// File: rtl/processor_multicycle.sv
// Multi-cycle single-issue core: sixteen general-purpose registers, an ALU with
// NZCV flags, conditional execution, and one unified word-addressed memory port
// that uses a req/ready handshake so memories with wait states are supported.
module processor_multicycle #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               MEM_W    = (DATA_W > 32) ? DATA_W : 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [MEM_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_ORR = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4, OP_MOV = 4'd5, OP_CMP = 4'd6, OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8, OP_LDR = 4'd9, OP_STR = 4'd10, OP_B = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd12, OP_NOP = 4'd13;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] result_q;

    logic [3:0]        f_cond, f_op, f_rd, f_rn, f_rm;
    logic              f_s, f_i;
    logic [DATA_W-1:0] op2_imm, rn_val, op2;
    logic [DATA_W:0]   add_full, sub_full, shl_full, shr_full;
    logic [DATA_W-1:0] alu_res;
    logic              c_new, v_new, cond_pass, flag_update, start_fetch;
    logic [3:0]        alu_flags;
    logic [ADDR_W-1:0] eff_addr, branch_target, fetch_addr;

    assign f_cond  = ir[31:28];
    assign f_op    = ir[27:24];
    assign f_s     = ir[23];
    assign f_i     = ir[22];
    assign f_rd    = ir[21:18];
    assign f_rn    = ir[17:14];
    assign f_rm    = ir[3:0];
    assign op2_imm = {{(DATA_W-14){1'b0}}, ir[13:0]};
    assign rn_val  = regs[f_rn];
    assign op2     = f_i ? op2_imm : regs[f_rm];

    // The extra top bit of the add/sub vectors is carry / borrow; the extra bit
    // of the shift vectors catches the last bit shifted out, and naturally
    // becomes 0 once the amount exceeds the data width.
    assign add_full = {1'b0, rn_val} + {1'b0, op2};
    assign sub_full = {1'b0, rn_val} - {1'b0, op2};
    assign shl_full = {1'b0, rn_val} << op2;
    assign shr_full = {rn_val, 1'b0} >> op2;

    assign eff_addr      = add_full[ADDR_W-1:0];
    assign branch_target = op2_imm[ADDR_W-1:0];
    assign halted        = (state == S_HALT);
    assign flag_update   = (f_op <= OP_LSR) && (f_s || f_op == OP_CMP);

    // ALU result and the flag values it would produce.
    always_comb begin
        alu_res = '0;
        c_new   = flags[1];
        v_new   = flags[0];
        case (f_op)
            OP_ADD: begin
                alu_res = add_full[DATA_W-1:0];
                c_new   = add_full[DATA_W];
                v_new   = (rn_val[DATA_W-1] == op2[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rn_val[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_full[DATA_W-1:0];
                c_new   = ~sub_full[DATA_W];
                v_new   = (rn_val[DATA_W-1] != op2[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rn_val[DATA_W-1]);
            end
            OP_AND: alu_res = rn_val & op2;
            OP_ORR: alu_res = rn_val | op2;
            OP_EOR: alu_res = rn_val ^ op2;
            OP_MOV: alu_res = op2;
            OP_LSL: begin
                alu_res = shl_full[DATA_W-1:0];
                if (op2 != '0) c_new = shl_full[DATA_W];
            end
            OP_LSR: begin
                alu_res = shr_full[DATA_W:1];
                if (op2 != '0) c_new = shr_full[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[DATA_W-1], (alu_res == '0), c_new, v_new};
    end

    // Condition code check against the current flags.
    always_comb begin
        cond_pass = 1'b0;
        case (f_cond)
            4'd0: cond_pass = 1'b1;
            4'd1: cond_pass = flags[2];
            4'd2: cond_pass = ~flags[2];
            4'd3: cond_pass = flags[1];
            4'd4: cond_pass = ~flags[1];
            4'd5: cond_pass = flags[3];
            4'd6: cond_pass = ~flags[3];
            4'd7: cond_pass = flags[0];
            4'd8: cond_pass = ~flags[0];
            default: cond_pass = 1'b0;
        endcase
    end

    // Sequencing: next state, plus whether a new instruction fetch must be issued.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_req && mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!cond_pass || f_op >= OP_NOP) state_nxt = S_FETCH;
                else if (f_op == OP_HALT)         state_nxt = S_HALT;
                else                              state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (f_op == OP_CMP || f_op == OP_B)        state_nxt = S_FETCH;
                else if (f_op == OP_LDR || f_op == OP_STR) state_nxt = S_MEM;
                else                                       state_nxt = S_WB;
            end
            S_MEM:    if (mem_ready) state_nxt = (f_op == OP_LDR) ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
        start_fetch = (state_nxt == S_FETCH) && !(state == S_FETCH && mem_req);
        fetch_addr  = (state == S_EXEC && f_op == OP_B) ? branch_target : pc;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Datapath and registered memory port; a new request is launched on the
    // edge that enters FETCH or MEM so a zero-wait access completes in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            flags     <= '0;
            result_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir      <= mem_rdata[31:0];
                        pc      <= pc + PC_ONE;
                        mem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (flag_update) flags <= alu_flags;
                    result_q <= alu_res;
                    if (f_op == OP_B) pc <= branch_target;
                    if (f_op == OP_LDR || f_op == OP_STR) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (f_op == OP_STR);
                        mem_addr  <= eff_addr;
                        mem_wdata <= regs[f_rd];
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        result_q <= mem_rdata[DATA_W-1:0];
                    end
                end
                S_WB:    regs[f_rd] <= result_q;
                default: ;
            endcase
            if (start_fetch) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= fetch_addr;
            end
        end
    end

endmodule

// File: doc/processor_multicycle.md
# processor_multicycle

Parametrised multi-cycle successor to the 32-bit processor top: a single-issue core with configurable data and address width, conditional execution on NZCV flags, and an external memory port with a req/ready handshake so wait-state memories are supported. The core holds the register bank, ALU, PC and a sequencing state machine. It talks to one unified, word-addressed instruction/data memory.

## Interface
- DATA_W, 32: datapath and register width; must be at least 16.
- ADDR_W, 16: memory word-address and PC width; must be at most DATA_W.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  32 or DATA_W  read data (instruction bits [31:0]); valid when mem_ready is high.
- mem_ready  in  1  transaction completes in a cycle where mem_req and mem_ready are both high.
- flags  out  4  {N,Z,C,V}.
- pc  out  ADDR_W  current PC.
- halted  out  1  core is in HALT.

## Operation
- Instruction word fields:
  - [31:28] cond
  - [27:24] op
  - [23] S
  - [22] I
  - [21:18] rd
  - [17:14] rn
  - [3:0] rm
  - [13:0] imm14
- Operand 2 (op2): zero-extended imm14 when I=1, otherwise R[rm].
- Sixteen registers, R0–R15, all general purpose.
- cond codes: 0 AL, 1 EQ Z, 2 NE !Z, 3 CS C, 4 CC !C, 5 MI N, 6 PL !N, 7 VS V, 8 VC !V, 9–15 never.
- op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR
  - 5 MOV: rd=op2
  - 6 CMP: rn−op2, flags only
  - 7 LSL, 8 LSR: rn shifted by op2
  - 9 LDR: rd=mem[rn+op2]
  - 10 STR: mem[rn+op2]=R[rd]
  - 11 B: pc=imm14[ADDR_W-1:0]
  - 12 HALT
  - 13–15 NOP
- Flags update only for ops 0–8, and only when S=1 or op=CMP.
  - N = result MSB; Z = result==0.
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = no-borrow (rn ≥ op2 unsigned), V = signed overflow.
  - Logic/MOV: C and V unchanged.
  - Shifts: C = last bit shifted out; unchanged if the amount is 0.
  - Shifts with amount ≥ DATA_W: result 0; C is the last bit out only if the amount equals DATA_W, otherwise 0.
- LDR/STR address = (rn+op2) truncated to ADDR_W bits.
- Arithmetic is modulo 2^DATA_W. PC increments by 1 and wraps at 2^ADDR_W.
- State machine:
  - FETCH: req read at pc; on ready latch IR and pc←pc+1; → DECODE.
  - DECODE: evaluate cond against current flags. Fail or NOP → FETCH. HALT → HALT. Otherwise → EXEC.
  - EXEC: ALU/flags. ALU-write op → WB. CMP → FETCH. B: pc←target, → FETCH. LDR/STR → MEM.
  - MEM: request; on ready, LDR → WB, STR → FETCH.
  - WB: write rd → FETCH.
  - HALT: sticky; halted=1, mem_req=0; exits only via reset.

## Timing
- Reset (async, immediate):
  - pc=RESET_PC, all registers 0, flags 0, state FETCH.
  - mem_req=0, mem_we=0, halted=0.
  - Asserting reset mid-transaction drops mem_req in the same cycle; the aborted access has no effect.
- First fetch request occurs in the first clock after reset deasserts.
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the completing edge. mem_req falls the cycle after completion.
- mem_ready while mem_req=0 is ignored.
- Latency with mem_ready tied high, fetch to next fetch:
  - ALU write: 4 cycles
  - CMP: 3
  - B: 3
  - STR: 4
  - LDR: 5
  - failed condition or NOP: 2
- Each memory wait cycle adds 1.
- Flags written in EXEC are visible to the next instruction's DECODE.
- A register written in WB is readable by the next instruction.
- rd equal to rn/rm reads the old value.

## Test plan
- Zero-wait memory, program MOV R1,#5; MOV R2,#7; ADD R3,R1,R2 (S=1) -> R3=12, flags=0000, ADD completes 4 cycles after its fetch.
- SUBS R4,R1,R1 then EQ-conditioned MOV R5,#1 and NE-conditioned MOV R6,#1 -> Z=1, C=1, R5=1, R6=0; the NE instruction takes 2 cycles.
- DATA_W=16: ADDS 0x7FFF+0x0001 -> result 0x8000, N=1, V=1, C=0. LSLS 0x8001 by 1 -> 0x0002, C=1.
- STR R3 to address 0x40, then LDR R7 from 0x40, with mem_ready held low 3 cycles per access -> R7=12; mem_addr/mem_we/mem_wdata stable throughout each wait.
- Branch to 0x10, then HALT -> pc=0x11, halted=1, mem_req stays 0 for 20 cycles.
- Assert reset during a waited fetch -> mem_req=0 immediately; after release pc=RESET_PC and registers read 0.
